// File: rtl/seq_divide_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_divide_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam string REP_UNSIGNED = "UNSIGNED";
  localparam string REP_SIGNED   = "SIGNED";

  // Width of a counter that must hold the value widthn itself.
  function automatic int cnt_width(input int widthn);
    return $clog2(widthn + 1);
  endfunction

endpackage

// File: rtl/seq_divide_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int lpm_widthd = 8
) (
  input  logic [lpm_widthd-1:0] rem,
  input  logic                  nbit,
  input  logic [lpm_widthd-1:0] dmag,
  output logic [lpm_widthd-1:0] rem_next,
  output logic                  qbit
);

  logic [lpm_widthd:0]   shifted;
  logic [lpm_widthd-1:0] diff;

  // The stored remainder is always below the divisor, so after the subtract
  // the result fits back into lpm_widthd bits; only the trial needs one more.
  always_comb begin
    shifted  = {rem, nbit};
    qbit     = (shifted >= {1'b0, dmag});
    diff     = shifted[lpm_widthd-1:0] - dmag;
    rem_next = qbit ? diff : shifted[lpm_widthd-1:0];
  end

endmodule

// File: rtl/seq_divide.sv
// Multi-cycle restoring divider, one quotient bit per enabled clock, with start/busy/done.
// Handshake: start is taken only in IDLE with clken high; busy is high from that edge until
// the result edge; done pulses for one enabled cycle with quotient/remain/div_by_zero valid.
module seq_divide
  import seq_divide_pkg::*;
#(
  parameter int    lpm_widthn         = 16,
  parameter int    lpm_widthd         = 8,
  parameter string lpm_representation = "UNSIGNED"
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  clken,
  input  logic                  start,
  input  logic [lpm_widthn-1:0] numer,
  input  logic [lpm_widthd-1:0] denom,
  output logic                  busy,
  output logic                  done,
  output logic [lpm_widthn-1:0] quotient,
  output logic [lpm_widthd-1:0] remain,
  output logic                  div_by_zero
);

  localparam bit IS_SIGNED = (lpm_representation == REP_SIGNED);
  localparam int CW        = cnt_width(lpm_widthn);

  state_t                state;
  logic [CW-1:0]         count;
  logic [lpm_widthn-1:0] nq;        // dividend bits shift out of the top, quotient bits in at the bottom
  logic [lpm_widthd-1:0] prem;
  logic [lpm_widthd-1:0] dmag;
  logic                  sign_n;
  logic                  sign_d;
  logic [lpm_widthd-1:0] numer_lo;
  logic                  dz;

  logic                  numer_neg;
  logic                  denom_neg;
  logic [lpm_widthn-1:0] numer_mag;
  logic [lpm_widthd-1:0] denom_mag;
  logic [lpm_widthd-1:0] step_rem;
  logic                  step_q;
  logic [lpm_widthn-1:0] q_fix;
  logic [lpm_widthd-1:0] r_fix;

  // Magnitudes as unsigned values: the most negative operand maps onto 2^(w-1).
  always_comb begin
    numer_neg = IS_SIGNED && numer[lpm_widthn-1];
    denom_neg = IS_SIGNED && denom[lpm_widthd-1];
    numer_mag = numer_neg ? (-numer) : numer;
    denom_mag = denom_neg ? (-denom) : denom;
  end

  div_step #(
    .lpm_widthd(lpm_widthd)
  ) u_step (
    .rem     (prem),
    .nbit    (nq[lpm_widthn-1]),
    .dmag    (dmag),
    .rem_next(step_rem),
    .qbit    (step_q)
  );

  // Truncation toward zero: quotient sign is the XOR of operand signs, remainder follows numer.
  always_comb begin
    q_fix = (sign_n ^ sign_d) ? (-nq) : nq;
    r_fix = sign_n ? (-prem) : prem;
  end

  always_ff @(posedge clock) begin
    if (aclr) begin
      state       <= IDLE;
      count       <= '0;
      nq          <= '0;
      prem        <= '0;
      dmag        <= '0;
      sign_n      <= 1'b0;
      sign_d      <= 1'b0;
      numer_lo    <= '0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remain      <= '0;
      div_by_zero <= 1'b0;
    end else if (clken) begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            nq       <= numer_mag;
            prem     <= '0;
            dmag     <= denom_mag;
            sign_n   <= numer_neg;
            sign_d   <= denom_neg;
            numer_lo <= numer[lpm_widthd-1:0];
            dz       <= (denom == '0);
            count    <= CW'(lpm_widthn);
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          nq    <= {nq[lpm_widthn-2:0], step_q};
          prem  <= step_rem;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          // Divide-by-zero bypasses sign correction and reports raw low numerator bits.
          quotient    <= dz ? '1 : q_fix;
          remain      <= dz ? numer_lo : r_fix;
          div_by_zero <= dz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divide.sv
// Directed bench for seq_divide: unsigned and signed instances on shared stimulus.
module tb_seq_divide;

  localparam int N = 16;
  localparam int D = 8;

  typedef struct {
    bit           sgn;
    logic [N-1:0] numer;
    logic [D-1:0] denom;
    logic [N-1:0] q;
    logic [D-1:0] r;
    logic         dz;
  } vec_t;

  // clock / reset block
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         aclr = 1'b1;
  logic         clken = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] numer = '0;
  logic [D-1:0] denom = '0;

  logic         busy_u, done_u, dz_u, busy_s, done_s, dz_s;
  logic [N-1:0] q_u, q_s;
  logic [D-1:0] r_u, r_s;

  bit           sel_sgn = 1'b0;
  logic         busy_m, done_m, dz_m;
  logic [N-1:0] q_m;
  logic [D-1:0] r_m;

  seq_divide #(.lpm_widthn(N), .lpm_widthd(D), .lpm_representation("UNSIGNED")) u_uns (
    .clock(clock), .aclr(aclr), .clken(clken), .start(start), .numer(numer), .denom(denom),
    .busy(busy_u), .done(done_u), .quotient(q_u), .remain(r_u), .div_by_zero(dz_u)
  );

  seq_divide #(.lpm_widthn(N), .lpm_widthd(D), .lpm_representation("SIGNED")) u_sgn (
    .clock(clock), .aclr(aclr), .clken(clken), .start(start), .numer(numer), .denom(denom),
    .busy(busy_s), .done(done_s), .quotient(q_s), .remain(r_s), .div_by_zero(dz_s)
  );

  always_comb begin
    busy_m = sel_sgn ? busy_s : busy_u;
    done_m = sel_sgn ? done_s : done_u;
    q_m    = sel_sgn ? q_s : q_u;
    r_m    = sel_sgn ? r_s : r_u;
    dz_m   = sel_sgn ? dz_s : dz_u;
  end

  // scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic check_next(input string name, input logic [31:0] act);
    logic [31:0] e;
    e = exp_q.pop_front();
    check(name, act, e);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_op(input logic [N-1:0] n, input logic [D-1:0] d);
    numer = n;
    denom = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns enabled-and-disabled cycles from accept to done (0 on timeout).
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (done_m) begin
        lat = i;
        break;
      end
      if (!busy_m) busy_ok = 1'b0;
    end
  endtask

  vec_t vecs[13];
  int   lat;
  bit   bok;
  bit   saw_done;

  initial begin
    vecs[0]  = '{0, 16'd1000,  8'd7,    16'd142,  8'd6,    1'b0};
    vecs[1]  = '{0, 16'h1234,  8'h00,   16'hFFFF, 8'h34,   1'b1};
    vecs[2]  = '{1, 16'hFF9C,  8'd7,    16'hFFF2, 8'hFE,   1'b0};
    vecs[3]  = '{1, 16'h8000,  8'hFF,   16'h8000, 8'h00,   1'b0};
    vecs[4]  = '{1, 16'd100,   8'hF9,   16'hFFF2, 8'h02,   1'b0};
    vecs[5]  = '{0, 16'hFFFF,  8'd1,    16'hFFFF, 8'h00,   1'b0};
    vecs[6]  = '{0, 16'd255,   8'd16,   16'd15,   8'd15,   1'b0};
    vecs[7]  = '{0, 16'd5,     8'd200,  16'd0,    8'd5,    1'b0};
    vecs[8]  = '{1, 16'hFFFF,  8'h00,   16'hFFFF, 8'hFF,   1'b1};
    vecs[9]  = '{1, 16'h8000,  8'h80,   16'h0100, 8'h00,   1'b0};
    vecs[10] = '{0, 16'hFFFF,  8'hFF,   16'h0101, 8'h00,   1'b0};
    vecs[11] = '{1, 16'd7,     8'h80,   16'h0000, 8'h07,   1'b0};
    vecs[12] = '{1, 16'hFFF9,  8'd2,    16'hFFFD, 8'hFF,   1'b0};

    // reset
    aclr = 1'b1;
    tick();
    tick();
    aclr = 1'b0;
    check("rst_u_outs", {busy_u, done_u, dz_u, q_u, r_u}, 32'd0);
    check("rst_s_outs", {busy_s, done_s, dz_s, q_s, r_s}, 32'd0);

    // table-driven vectors
    foreach (vecs[i]) begin
      sel_sgn = vecs[i].sgn;
      exp_q.push_back(32'(vecs[i].q));
      exp_q.push_back(32'(vecs[i].r));
      exp_q.push_back(32'(vecs[i].dz));
      start_op(vecs[i].numer, vecs[i].denom);
      check($sformatf("v%0d_busy_accept", i), 32'(busy_m), 32'd1);
      wait_done(lat, bok);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd17);
      check($sformatf("v%0d_busy_held", i), 32'(bok), 32'd1);
      check_next($sformatf("v%0d_quotient", i), 32'(q_m));
      check_next($sformatf("v%0d_remain", i), 32'(r_m));
      check_next($sformatf("v%0d_dz", i), 32'(dz_m));
      check($sformatf("v%0d_busy_at_done", i), 32'(busy_m), 32'd0);
      tick();
      check($sformatf("v%0d_done_pulse", i), 32'(done_m), 32'd0);
    end

    // clken stall of 5 cycles in CALC plus an ignored start while busy
    sel_sgn = 1'b0;
    start_op(16'd1000, 8'd7);
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 4) clken = 1'b0;
      if (i == 9) clken = 1'b1;
      if (i == 10) begin
        numer = 16'd5;
        denom = 8'd1;
        start = 1'b1;
      end
      if (i == 11) start = 1'b0;
      tick();
      if (done_m) begin
        lat = i;
        break;
      end
    end
    check("stall_latency", 32'(lat), 32'd22);
    check("stall_quotient", 32'(q_m), 32'd142);
    check("stall_remain", 32'(r_m), 32'd6);
    // done stretches across disabled cycles
    clken = 1'b0;
    tick();
    tick();
    check("done_hold_clken_low", 32'(done_m), 32'd1);
    clken = 1'b1;
    tick();
    check("done_clears_enabled", 32'(done_m), 32'd0);
    check("ignored_start_no_busy", 32'(busy_m), 32'd0);

    // start held high: not accepted in FIX, accepted on the done cycle edge
    numer = 16'd1000;
    denom = 8'd7;
    start = 1'b1;
    tick();
    wait_done(lat, bok);
    check("b2b_first_latency", 32'(lat), 32'd17);
    tick();
    start = 1'b0;
    check("b2b_accept_busy", 32'(busy_m), 32'd1);
    check("b2b_accept_done_low", 32'(done_m), 32'd0);
    wait_done(lat, bok);
    check("b2b_second_latency", 32'(lat), 32'd17);
    check("b2b_quotient", 32'(q_m), 32'd142);
    tick();

    // aclr mid-operation
    start_op(16'd1000, 8'd7);
    for (int i = 0; i < 8; i++) tick();
    aclr = 1'b1;
    tick();
    aclr = 1'b0;
    check("aclr_outs", {busy_m, done_m, dz_m, q_m, r_m}, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_m || busy_m) saw_done = 1'b1;
    end
    check("aclr_no_done", 32'(saw_done), 32'd0);
    start_op(16'd255, 8'd16);
    wait_done(lat, bok);
    check("post_aclr_latency", 32'(lat), 32'd17);
    check("post_aclr_quotient", 32'(q_m), 32'd15);
    check("post_aclr_remain", 32'(r_m), 32'd15);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divide.md
# seq_divide

Multi-cycle restoring divider, the inverse arithmetic element to the pipelined multiply-accumulate used in the convolution datapath. It computes `numer / denom` and produces a quotient and remainder, one quotient bit per enabled clock. Average-pooling and normalization stages use it where a combinational divider would not meet timing. A start/busy/done handshake lets a controller issue one division at a time.

## Interface
- `lpm_widthn`, 16: numerator and quotient width, ≥2.
- `lpm_widthd`, 8: denominator and remainder width, 2..`lpm_widthn`.
- `lpm_representation`, "UNSIGNED": either "UNSIGNED" or "SIGNED" (two's complement). Applies to both operands.
- `clock` input 1: single clock, rising edge.
- `aclr` input 1: reset, synchronous, active-high. Overrides `clken`.
- `clken` input 1: clock enable. When low, all state and outputs hold.
- `start` input 1: request a division. Sampled only in IDLE with `clken` high.
- `numer` input `lpm_widthn`: dividend. Captured on the accepted `start`.
- `denom` input `lpm_widthd`: divisor. Captured on the accepted `start`.
- `busy` output 1: high from the accept edge until the result edge.
- `done` output 1: one enabled-cycle pulse. Results are valid on this cycle.
- `quotient` output `lpm_widthn`: result. Holds until the next result or reset.
- `remain` output `lpm_widthd`: remainder. Holds the same way.
- `div_by_zero` output 1: qualifies the current `quotient`/`remain`. Holds with them.

## Operation
- States: IDLE, CALC, FIX. Reset enters IDLE.
- Reset values: all outputs 0, iteration counter 0.
- IDLE: `start`=1 and `clken`=1 captures the operands and loads the counter with `lpm_widthn`.
  - SIGNED: operand magnitudes and the two sign bits are stored.
  - Next state is CALC and `busy` rises.
- CALC: each enabled edge performs one restoring step.
  - Partial remainder, `lpm_widthd`+1 bits, is shifted left and takes in the next numerator MSB.
  - The denominator magnitude is subtracted. If the result is non-negative, it is kept and quotient bit 1 is shifted in; otherwise the remainder is restored and bit 0 is shifted in.
  - The counter decrements. At 1, the next state is FIX.
- FIX: one cycle of sign correction. It registers `quotient`/`remain`/`div_by_zero`, asserts `done`, clears `busy`, and returns to IDLE.
- SIGNED result rules:
  - Truncation toward zero. The quotient is negated when the operand signs differ; the remainder takes the sign of `numer`.
  - −2^(N−1) / −1 wraps: `quotient` = −2^(N−1), `remain` = 0, no flag.
- `denom` = 0 keeps the normal latency:
  - `quotient` = all ones.
  - `remain` = `numer[lpm_widthd-1:0]`.
  - `div_by_zero` = 1.
- `start` while `busy` is ignored; it is neither queued nor allowed to corrupt operands.
- `start` on the same edge `done` is asserted is not accepted, because the FSM is still in FIX. The earliest accept is the next enabled edge.
- `aclr` mid-operation: the FSM returns to IDLE, outputs clear, no `done` is produced, and the operation is lost.

## Timing
- Accept edge E0. CALC runs on edges E1..EN, where N = `lpm_widthn`. FIX/result at edge E(N+1).
- Result latency is N+1 enabled edges after accept. Issue interval is at least N+2 enabled cycles.
- `done` is high for exactly one enabled cycle after E(N+1). If `clken` drops during that cycle, `done` stays high until the next enabled edge.
- `clken` low for k cycles anywhere in CALC/FIX delays `done` by exactly k cycles. No partial step is taken.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `seq_divide_pkg`:
  - state enum (IDLE, CALC, FIX);
  - representation string constants;
  - a function returning counter width, `$clog2(lpm_widthn+1)`.
- Sub-module `div_step`: combinational single restoring iteration. Inputs are partial remainder, numerator bit, and divisor magnitude; outputs are the next remainder and the quotient bit. Instantiated once.
- Top level: FSM, operand/sign capture, counter, magnitude/negation logic, output registers. Target 150–250 lines.

## Test plan
Configuration: `lpm_widthn`=16, `lpm_widthd`=8.
- UNSIGNED 1000/7 → `quotient`=142, `remain`=6, `div_by_zero`=0. `done` is 17 cycles after the accept edge, with `busy` high over the 17 edges in between.
- UNSIGNED 0x1234/0 → `quotient`=0xFFFF, `remain`=0x34, `div_by_zero`=1, same latency.
- SIGNED −100/7 → `quotient`=0xFFF2 (−14), `remain`=0xFE (−2).
- SIGNED 0x8000/0xFF (−32768/−1) → `quotient`=0x8000, `remain`=0.
- SIGNED 100/−7 → `quotient`=0xFFF2, `remain`=0x02.
- 1000/7 with `clken` low for 5 cycles during CALC → `done` at 22 cycles and correct results. A `start` pulsed with 5/1 while busy is ignored, and the results stay 142/6.
- `aclr` 8 cycles into 1000/7 → next cycle all outputs are 0, `busy`=0, and no `done`. A fresh 255/16 then gives 15/15 at 17 cycles.
